// File: rtl/acq_trigger_ctrl_pkg.sv
// Shared types for the acquisition trigger controller: FSM states and edge-select encoding.
package acq_trigger_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE_FILL = 3'd1,
        ARMED    = 3'd2,
        POST     = 3'd3,
        DONE     = 3'd4
    } acq_state_e;

    localparam logic EDGE_RISING  = 1'b0;
    localparam logic EDGE_FALLING = 1'b1;

endpackage

// File: rtl/acq_trigger_ctrl_trigger_detect.sv
// Combinational level-crossing comparator; reused by the digital trigger path.
module acq_trigger_ctrl_trigger_detect
    import acq_trigger_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] prev_i,
    input  logic [DATA_WIDTH-1:0] cur_i,
    input  logic [DATA_WIDTH-1:0] level_i,
    input  logic                  edge_i,
    output logic                  trig_hit_o
);

    always_comb begin
        trig_hit_o = 1'b0;
        if (edge_i == EDGE_FALLING) begin
            trig_hit_o = (prev_i > level_i) && (cur_i <= level_i);
        end else begin
            trig_hit_o = (prev_i < level_i) && (cur_i >= level_i);
        end
    end

endmodule

// File: rtl/acq_trigger_ctrl.sv
// Captures ADC samples into a circular RAM around a level/edge trigger with a
// programmable pre-trigger depth, then reports trigger and start addresses.
module acq_trigger_ctrl
    import acq_trigger_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] SI_data,
    input  logic                  SI_rdy,
    output logic                  SI_ack,
    input  logic                  start_i,
    input  logic                  force_trig_i,
    input  logic [DATA_WIDTH-1:0] trig_level_i,
    input  logic                  trig_falling_i,
    input  logic [ADDR_WIDTH-1:0] pretrig_i,
    input  logic [ADDR_WIDTH-1:0] num_samples_i,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    output logic [ADDR_WIDTH-1:0] trig_addr_o,
    output logic [ADDR_WIDTH-1:0] start_addr_o,
    output logic                  busy_o,
    output logic                  done_o
);

    acq_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic [ADDR_WIDTH-1:0] post_cnt_q, post_cnt_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic                  prev_valid_q, prev_valid_d;
    logic                  force_pend_q, force_pend_d;
    logic [ADDR_WIDTH-1:0] pre_q, pre_d;
    logic [ADDR_WIDTH-1:0] num_q, num_d;
    logic [DATA_WIDTH-1:0] level_q, level_d;
    logic                  fall_q, fall_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  xfer;
    logic                  trig_hit;
    logic                  fire;
    logic [ADDR_WIDTH-1:0] num_eff;
    logic [ADDR_WIDTH-1:0] pre_eff;

    // Samples are always drained so the front-end never stalls.
    assign SI_ack = ~rst;
    assign xfer   = SI_rdy & SI_ack;

    assign num_eff = (num_samples_i == '0) ? ADDR_WIDTH'(1) : num_samples_i;
    assign pre_eff = (pretrig_i > num_eff - ADDR_WIDTH'(1)) ? num_eff - ADDR_WIDTH'(1) : pretrig_i;

    acq_trigger_ctrl_trigger_detect #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_trigger_detect (
        .prev_i     (prev_q),
        .cur_i      (SI_data),
        .level_i    (level_q),
        .edge_i     (fall_q),
        .trig_hit_o (trig_hit)
    );

    assign fire = force_trig_i | force_pend_q | (prev_valid_q & trig_hit);

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            force_pend_q <= 1'b0;
            pre_q        <= '0;
            num_q        <= '0;
            level_q      <= '0;
            fall_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            force_pend_q <= force_pend_d;
            pre_q        <= pre_d;
            num_q        <= num_d;
            level_q      <= level_d;
            fall_q       <= fall_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        force_pend_d = force_pend_q;
        pre_d        = pre_q;
        num_d        = num_q;
        level_d      = level_q;
        fall_d       = fall_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;

        if (start_i) begin
            // A start pulse restarts from any state and discards a coincident sample.
            pre_d        = pre_eff;
            num_d        = num_eff;
            level_d      = trig_level_i;
            fall_d       = trig_falling_i;
            wr_ptr_d     = '0;
            pre_cnt_d    = '0;
            post_cnt_d   = '0;
            prev_valid_d = 1'b0;
            force_pend_d = 1'b0;
            state_d      = (pre_eff == '0) ? ARMED : PRE_FILL;
        end else begin
            if (xfer && (state_q == PRE_FILL || state_q == ARMED || state_q == POST)) begin
                we_d         = 1'b1;
                addr_d       = wr_ptr_q;
                data_d       = SI_data;
                wr_ptr_d     = wr_ptr_q + ADDR_WIDTH'(1);
                prev_d       = SI_data;
                prev_valid_d = 1'b1;
            end
            case (state_q)
                PRE_FILL: begin
                    if (xfer) begin
                        pre_cnt_d = pre_cnt_q + ADDR_WIDTH'(1);
                        if (pre_cnt_q + ADDR_WIDTH'(1) == pre_q) begin
                            state_d = ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (xfer) begin
                        if (fire) begin
                            trig_addr_d  = wr_ptr_q;
                            start_addr_d = wr_ptr_q - pre_q;
                            force_pend_d = 1'b0;
                            post_cnt_d   = num_q - pre_q - ADDR_WIDTH'(1);
                            state_d      = (num_q - pre_q == ADDR_WIDTH'(1)) ? DONE : POST;
                        end
                    end else if (force_trig_i) begin
                        force_pend_d = 1'b1;
                    end
                end
                POST: begin
                    if (xfer) begin
                        post_cnt_d = post_cnt_q - ADDR_WIDTH'(1);
                        if (post_cnt_q == ADDR_WIDTH'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == PRE_FILL) || (state_d == ARMED) || (state_d == POST);
        done_d = (state_d == DONE);
    end

    assign ram_we_o     = we_q;
    assign ram_addr_o   = addr_q;
    assign ram_data_o   = data_q;
    assign trig_addr_o  = trig_addr_q;
    assign start_addr_o = start_addr_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
